cache_fill_responder: RTL

Backend-side responder for the pipelined LRU way cache. It accepts line-fill requests (one tag per request) on a stream slave and returns the addressed cache line as `LINE_SIZE/DATA_PORT_SIZE` consecutive beats on a stream master. Lines are held in a local synchronous-read line memory, preloaded through a simple write port. The block sits between the cache's backend address/data streams and the card's lookup-table storage, and serves as the bench-side memory model for cache verification.

---
 rtl/cache_fill_responder_if.sv | 16 +
 rtl/cache_fill_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_responder_if.sv
// rtl/cache_fill_responder_if.sv - valid/ready stream bundle used by the fill responder
// Purpose: one unidirectional stream channel, parameterised on payload width.
// Signals:
//   tdata  [W-1:0]  payload, driven by master
//   tvalid          payload valid, driven by master
//   tready          sink can accept, driven by slave
interface cache_fill_responder_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cache_fill_responder.sv
// rtl/cache_fill_responder.sv - returns preloaded cache lines as beat bursts per fill request
// Purpose: accepts one tag per request, queues it, reads the addressed line from a
//   local synchronous line memory and streams it out as BEATS beats, beat 0 first.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   req_stream (slave)  fill requests, tdata = tag (low IDX_W bits select the line)
//   rsp_stream (master) fill data beats
//   rsp_last            marks the final beat of a line
//   wr_en/wr_addr/wr_data  preload port, word address = line*BEATS + beat
//   busy                any request queued, read pending or beat buffered
//   req_count           accepted requests, wrapping
module cache_fill_responder #(
  parameter int TAGS_WIDTH     = 48,
  parameter int LINE_SIZE      = 512,
  parameter int DATA_PORT_SIZE = 512,
  parameter int LINE_DEPTH     = 1024,
  parameter int MEM_LATENCY    = 2,
  parameter int REQ_FIFO_DEPTH = 4,
  localparam int BEATS = LINE_SIZE / DATA_PORT_SIZE,
  localparam int IDX_W = $clog2(LINE_DEPTH),
  localparam int AW    = IDX_W + $clog2(BEATS)
) (
  input  logic                      clk,
  input  logic                      rstn,
  cache_fill_responder_if.slave     req_stream,
  cache_fill_responder_if.master    rsp_stream,
  output logic                      rsp_last,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DATA_PORT_SIZE-1:0] wr_data,
  output logic                      busy,
  output logic [31:0]               req_count
);

  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RQ_PW     = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int RQ_CW     = $clog2(REQ_FIFO_DEPTH + 1);
  localparam int OB_DEPTH  = MEM_LATENCY + 2;
  localparam int OB_PW     = $clog2(OB_DEPTH);
  localparam int OB_CW     = $clog2(OB_DEPTH + 1);
  localparam int MEM_WORDS = LINE_DEPTH * BEATS;

  // ---------------- request FIFO (stores only the line index) ----------------
  logic [IDX_W-1:0] rq_mem [REQ_FIFO_DEPTH];
  logic [RQ_PW-1:0] rq_wp, rq_rp;
  logic [RQ_CW-1:0] rq_cnt, rq_cnt_d;
  logic             rq_tready, rq_push, rq_pop, rq_empty;
  logic [IDX_W-1:0] rq_head;
  logic             unused_tag;

  // Upper tag bits carry no meaning for this block.
  assign unused_tag        = ^req_stream.tdata;
  assign req_stream.tready = rq_tready;
  assign rq_push           = req_stream.tvalid & rq_tready;
  assign rq_empty          = (rq_cnt == '0);
  assign rq_head           = rq_mem[rq_rp];

  always_comb begin
    rq_cnt_d = rq_cnt;
    if (rq_push && !rq_pop) begin
      rq_cnt_d = rq_cnt + RQ_CW'(1);
    end else if (!rq_push && rq_pop) begin
      rq_cnt_d = rq_cnt - RQ_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rq_wp     <= '0;
      rq_rp     <= '0;
      rq_cnt    <= '0;
      rq_tready <= 1'b0;
      req_count <= '0;
    end else begin
      if (rq_push) begin
        rq_mem[rq_wp] <= req_stream.tdata[IDX_W-1:0];
        rq_wp         <= (rq_wp == RQ_PW'(REQ_FIFO_DEPTH - 1)) ? '0 : rq_wp + RQ_PW'(1);
        req_count     <= req_count + 32'd1;
      end
      if (rq_pop) begin
        rq_rp <= (rq_rp == RQ_PW'(REQ_FIFO_DEPTH - 1)) ? '0 : rq_rp + RQ_PW'(1);
      end
      rq_cnt    <= rq_cnt_d;
      // Registered ready: reflects the occupancy that will hold next cycle.
      rq_tready <= (rq_cnt_d != RQ_CW'(REQ_FIFO_DEPTH));
    end
  end

  // ---------------- read FSM ----------------
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rd_en, rd_last, credit_ok;
  logic [AW-1:0]     rd_addr;
  logic [OB_CW-1:0]  ob_cnt, inflight;

  // A read may only start if its data is guaranteed a slot in the output buffer.
  assign credit_ok = (ob_cnt + inflight) < OB_CW'(OB_DEPTH);
  assign rd_last   = (beat_q == BEAT_W'(BEATS - 1));
  assign rd_addr   = AW'(idx_q) * AW'(BEATS) + AW'(beat_q);

  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    beat_d  = beat_q;
    rq_pop  = 1'b0;
    rd_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rq_empty) begin
          rq_pop  = 1'b1;
          idx_d   = rq_head;
          beat_d  = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (rd_last) begin
            // Chain straight into the next line so bursts run without a bubble.
            if (!rq_empty) begin
              rq_pop = 1'b1;
              idx_d  = rq_head;
              beat_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      beat_q <= '0;
    end else begin
      state  <= state_d;
      idx_q  <= idx_d;
      beat_q <= beat_d;
    end
  end

  // ---------------- line memory, read-first, MEM_LATENCY deep ----------------
  logic [DATA_PORT_SIZE-1:0] mem       [MEM_WORDS];
  logic [DATA_PORT_SIZE-1:0] pipe_data [MEM_LATENCY];
  logic [MEM_LATENCY-1:0]    pipe_vld, pipe_last;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    pipe_data[0] <= mem[rd_addr];
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // Only the tags are reset; clearing them is enough to discard in-flight data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_last[0] <= rd_last;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + OB_CW'(pipe_vld[i]);
    end
  end

  // ---------------- output buffer ----------------
  logic [DATA_PORT_SIZE-1:0] ob_data [OB_DEPTH];
  logic [OB_DEPTH-1:0]       ob_last;
  logic [OB_PW-1:0]          ob_wp, ob_rp;
  logic                      ob_push, ob_pop, ob_valid;

  assign ob_push           = pipe_vld[MEM_LATENCY-1];
  assign ob_valid          = (ob_cnt != '0);
  assign ob_pop            = ob_valid & rsp_stream.tready;
  assign rsp_stream.tvalid = ob_valid;
  // Gated so the outputs read zero whenever nothing is presented.
  assign rsp_stream.tdata  = ob_valid ? ob_data[ob_rp] : '0;
  assign rsp_last          = ob_valid & ob_last[ob_rp];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ob_wp  <= '0;
      ob_rp  <= '0;
      ob_cnt <= '0;
    end else begin
      if (ob_push) begin
        ob_data[ob_wp] <= pipe_data[MEM_LATENCY-1];
        ob_last[ob_wp] <= pipe_last[MEM_LATENCY-1];
        ob_wp          <= (ob_wp == OB_PW'(OB_DEPTH - 1)) ? '0 : ob_wp + OB_PW'(1);
      end
      if (ob_pop) begin
        ob_rp <= (ob_rp == OB_PW'(OB_DEPTH - 1)) ? '0 : ob_rp + OB_PW'(1);
      end
      case ({ob_push, ob_pop})
        2'b10:   ob_cnt <= ob_cnt + OB_CW'(1);
        2'b01:   ob_cnt <= ob_cnt - OB_CW'(1);
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

  assign busy = !rq_empty || (state == S_BURST) || (|pipe_vld) || ob_valid;

endmodule
